// File: rtl/codebreaker_onchip_ram_pipelined_if.sv
// Avalon-MM bus bundle for the pipelined on-chip RAM.
// The master drives the request fields; the slave returns read data, the
// read strobe and back-pressure.
interface codebreaker_onchip_ram_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output chipselect, address, byteenable, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, address, byteenable, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/codebreaker_onchip_ram_pipelined.sv
// Parametrised single-port on-chip RAM with an Avalon-MM slave port.
// Byte-lane writes, 1- or 2-cycle read latency with readdatavalid,
// waitrequest back-pressure, and zero-returning out-of-range reads.
// Optional feature: define CODEBREAKER_RAM_CLEAR_ON_RESET_EN to zero the
// whole array, one word per enabled cycle, after every reset release.
module codebreaker_onchip_ram_pipelined #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16384,
    parameter int ADDR_W       = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_req,
    input  logic clken,
    codebreaker_onchip_ram_pipelined_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH = 2^ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

`ifdef CODEBREAKER_RAM_CLEAR_ON_RESET_EN
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t RESET_STATE = ST_CLEAR;
`else
    typedef enum logic {
        ST_READY
    } state_t;

    localparam state_t RESET_STATE = ST_READY;
`endif

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q;
    state_t            state_d;
    logic              ready;
    logic              en;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

`ifdef CODEBREAKER_RAM_CLEAR_ON_RESET_EN
    logic [ADDR_W:0]   clr_cnt_q;
    logic [ADDR_W:0]   clr_cnt_d;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;
`endif

    assign en       = clken & ~reset_req;
    assign in_range = ({1'b0, bus.address} < DEPTH_EXT);
    assign idx      = bus.address[IDX_W-1:0];

    // Back-pressure: stalled while disabled, in reset, or not yet ready.
    assign bus.waitrequest = ~en | reset | ~ready;

    // Request qualification; a write wins over a simultaneous read.
    always_comb begin
        accept = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
        wr_acc = accept & bus.write;
        rd_acc = accept & bus.read & ~bus.write;
    end

    // FSM state (and clear counter) register; frozen while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_STATE;
`ifdef CODEBREAKER_RAM_CLEAR_ON_RESET_EN
            clr_cnt_q <= '0;
`endif
        end else if (en) begin
            state_q   <= state_d;
`ifdef CODEBREAKER_RAM_CLEAR_ON_RESET_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

`ifdef CODEBREAKER_RAM_CLEAR_ON_RESET_EN
    // Next state: walk 0..DEPTH-1 writing zero, then open the port.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        ready     = (state_q == ST_READY);
        clr_idx   = clr_cnt_q[IDX_W-1:0];
        case (state_q)
            ST_CLEAR: begin
                clr_we = en & ~reset;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end
`else
    // Next state: the port is ready as soon as reset releases.
    always_comb begin
        state_d = ST_READY;
        ready   = (state_q == ST_READY);
    end
`endif

    // Memory array: clear sweep or byte-lane writes; out-of-range writes drop.
    always_ff @(posedge clk) begin
`ifdef CODEBREAKER_RAM_CLEAR_ON_RESET_EN
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else
`endif
        if (wr_acc && in_range) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (bus.byteenable[i]) begin
                    mem[idx][i*8 +: 8] <= bus.writedata[i*8 +: 8];
                end
            end
        end
    end

    // First read stage: array lookup; data only changes on an accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (en) begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= in_range ? mem[idx] : '0;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              out_valid;
        logic [DATA_W-1:0] out_data;

        // Output register stage; holds last data between strobes.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else if (en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s1_data;
                end
            end
        end

        // A strobe pending across a stall stays in out_valid and is only
        // exposed once the block is enabled again.
        assign bus.readdata      = out_data;
        assign bus.readdatavalid = out_valid & en & ~reset;
    end else begin : g_lat1
        assign bus.readdata      = s1_data;
        assign bus.readdatavalid = s1_valid & en & ~reset;
    end

endmodule

// File: doc/codebreaker_onchip_ram_pipelined.md
Name: codebreaker_onchip_ram_pipelined

Overview:
Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It is the next generation of the system's on-chip memory and adds configurable width and depth, a configurable read latency with readdatavalid, waitrequest back-pressure and out-of-range address handling. It sits on the system interconnect as program/data memory for the soft processor and as scratch storage for the code-breaking datapath.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
DEPTH, 16384, number of words; need not be a power of two.
ADDR_W, 14, address width; must satisfy 2^ADDR_W >= DEPTH.
READ_LATENCY, 1, cycles from an accepted read to readdatavalid; legal values are 1 or 2. A value of 2 adds an output register.

Ports:
clk  in  1  single clock; all logic rises on this edge
reset  in  1  synchronous, active-high reset
reset_req  in  1  reset-in-progress request; when high, acts as clken=0
clken  in  1  clock enable; when low, the whole block stalls
chipselect  in  1  slave select
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  per-byte write enable
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
readdata  out  DATA_W  read data, valid only when readdatavalid=1
readdatavalid  out  1  one-cycle strobe, one per accepted read
waitrequest  out  1  when high, the current request is not accepted

Behaviour:
- Enable: en = clken & ~reset_req. When en=0, memory, the read pipeline and the FSM hold state. waitrequest is high while en=0. readdatavalid is held low while en=0, and a pending strobe is delivered after en returns.
- Reset values (while reset=1 and on the first cycle after): readdata=0, readdatavalid=0, waitrequest=1, read pipeline flushed. Reads in flight when reset asserts are discarded and never produce readdatavalid. Memory contents are not altered by reset, except as described under the optional feature.
- Acceptance: a request is accepted on a rising edge with chipselect=1, (read|write)=1, waitrequest=0 and en=1.
- Throughput: one request per cycle, fully pipelined.
- Write: each byte lane i with byteenable[i]=1 is written. A write with byteenable=0 is accepted and has no effect.
- Write/read priority: if read and write are both high, the write is performed, the read is ignored and no readdatavalid is produced.
- Read latency: an accepted read at edge N produces readdatavalid=1 with its data after edge N+READ_LATENCY, counted in en=1 cycles.
  - Back-to-back reads give back-to-back strobes, in order.
  - readdata holds its last value when readdatavalid=0.
- Read-after-write: a read accepted on the edge after a write to the same address returns the new data.
- Out of range (address >= DEPTH): writes are accepted and dropped. Reads are accepted and return 0 with the normal latency and strobe. There is no wrap-around.
- FSM states: CLEAR (present only with the optional feature) and READY.
  - Without the feature: READY from reset release; waitrequest = ~en | reset.
  - With the feature: see Optional Feature.
- Width rules:
  - The address is compared against DEPTH at ADDR_W+1 bits.
  - The clear counter is ADDR_W+1 bits so that DEPTH = 2^ADDR_W terminates correctly.

Optional Feature:
Macro: CODEBREAKER_RAM_CLEAR_ON_RESET_EN.
- Defined:
  - After reset releases, the FSM enters CLEAR and writes all-zero to addresses 0..DEPTH-1, one word per en=1 cycle.
  - waitrequest stays high throughout. It drops on the cycle after the write to address DEPTH-1, when the FSM enters READY.
  - Total clear time is DEPTH en-cycles.
  - Reset asserted mid-clear restarts the clear at address 0.
  - Requests presented during CLEAR are stalled, not dropped.
- Not defined: the CLEAR state and counter are absent, and memory is uninitialised after reset.

Test Plan:
- Byte-lane write: write 0xDEADBEEF to addr 5 with byteenable=0xF, then 0x000000AA with byteenable=0x1, then read addr 5 -> readdata=0xDEADBEAA.
- Latency and ordering: write addrs 0..3 with 0x10..0x13, then issue 4 back-to-back reads, for READ_LATENCY=1 and 2 -> 4 consecutive readdatavalid strobes starting 1 (resp. 2) cycles after the first read, with data 0x10, 0x11, 0x12, 0x13.
- Stall: clken=0 for 3 cycles in the middle of a 4-read burst -> waitrequest=1 during the stall; no data lost or duplicated; exactly 4 strobes, in order.
- Bounds: with DEPTH=1000, write 0x55 to addr 1000, then read addr 1000 and addr 999 -> addr 1000 returns 0 with a strobe; the contents of addr 999 are unchanged.
- Reset mid-read: assert reset one cycle after a read is accepted with READ_LATENCY=2 -> no readdatavalid is produced; readdata=0 after reset.
- With CODEBREAKER_RAM_CLEAR_ON_RESET_EN and DEPTH=16:
  - Reset, then check waitrequest and then read every address -> waitrequest=1 for exactly 16 cycles after reset release; every address reads 0.
  - Re-assert reset at clear step 7 -> the clear restarts and waitrequest stays high for 16 more cycles.
